// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: RAM frame store that commits whole frames on tlast and drops errored/short/long/overflowed frames.
// Define RX_FB_CRC_EN to check and strip a trailing CRC-8 (poly 0x07, init 0, MSB first) on every frame.
module rx_frame_buffer #(
  parameter int ADDR_W  = 10,
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 255
) (
  input  logic        clk_32M768,
  input  logic        rst_32M768,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic        s_tuser,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_drop,
  output logic        overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
`ifdef RX_FB_CRC_EN
  // The CRC beat is counted in len but is not payload, and an empty payload never commits.
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'((MIN_LEN < 1 ? 1 : MIN_LEN) + 1);
`else
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
`endif
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_cur, len_nxt;
  logic              bad_q, bad_d, bad_cur;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d, used;
  logic [15:0]       ok_cnt_q, ok_cnt_d, drop_cnt_q, drop_cnt_d;
  logic              ovf_q, ovf_d;
  logic              want_wr, tail_ok;
  logic              ram_we;
  logic [8:0]        ram_wdat;
  logic [8:0]        ram_rdat_q;
  logic [8:0]        mem [DEPTH];
  logic              rd_en, out_free;
  logic              pend_vld_q, pend_vld_d;
  logic              out_vld_q, out_vld_d;
  logic [8:0]        out_dat_q, out_dat_d;

`ifdef RX_FB_CRC_EN
  logic [7:0] hold_q, hold_d, crc_q, crc_d, crc_cur;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] dat);
    logic [7:0] c;
    c = crc ^ dat;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bad_d       = bad_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    ok_cnt_d    = ok_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = ovf_q;
    ram_we      = 1'b0;
    used        = wr_ptr_q - rd_ptr_q;
    len_cur     = (state_q == RECV) ? len_q : '0;
    bad_cur     = (state_q == RECV) && bad_q;
    len_nxt     = (len_cur == LEN_SAT) ? len_cur : len_cur + LEN_ONE;
`ifdef RX_FB_CRC_EN
    hold_d   = hold_q;
    crc_d    = crc_q;
    crc_cur  = (state_q == RECV) ? crc_q : 8'h00;
    want_wr  = (state_q == RECV);
    ram_wdat = {s_tlast, hold_q};
    tail_ok  = (s_tdata == crc_cur);
    if (s_tvalid && !s_tlast) begin
      hold_d = s_tdata;
      crc_d  = crc8_step(crc_cur, s_tdata);
    end
`else
    want_wr  = 1'b1;
    ram_wdat = {s_tlast, s_tdata};
    tail_ok  = 1'b1;
`endif
    if (s_tvalid) begin
      state_d = RECV;
      len_d   = len_nxt;
      bad_d   = bad_cur || s_tuser || (len_nxt > LEN_MAX);
      if (want_wr && !bad_cur) begin
        // used[ADDR_W] set means every slot holds unread data.
        if (used[ADDR_W]) begin
          bad_d = 1'b1;
          ovf_d = 1'b1;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
      end
      if (s_tlast) begin
        state_d = IDLE;
        if (!bad_d && tail_ok && (len_nxt >= LEN_MIN)) begin
          wr_commit_d = wr_ptr_d;
          ok_cnt_d    = ok_cnt_q + 16'd1;
        end else begin
          wr_ptr_d    = wr_commit_q;
          drop_cnt_d  = drop_cnt_q + 16'd1;
        end
      end
    end
  end

  // Two-stage read: RAM output register then output register, refilled whenever the next stage can take data.
  always_comb begin
    out_free   = !out_vld_q || m_tready;
    rd_en      = (rd_ptr_q != wr_commit_q) && (!pend_vld_q || out_free);
    rd_ptr_d   = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    pend_vld_d = pend_vld_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    if (out_free) begin
      out_vld_d = pend_vld_q;
      if (pend_vld_q) out_dat_d = ram_rdat_q;
    end
    if (rd_en) begin
      pend_vld_d = 1'b1;
    end else if (out_free) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_32M768) begin
    if (ram_we) mem[wr_ptr_q[ADDR_W-1:0]] <= ram_wdat;
    if (rd_en)  ram_rdat_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      state_q     <= IDLE;
      len_q       <= '0;
      bad_q       <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      ok_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
`ifdef RX_FB_CRC_EN
      hold_q      <= '0;
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      ok_cnt_q    <= ok_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
      pend_vld_q  <= pend_vld_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
`ifdef RX_FB_CRC_EN
      hold_q      <= hold_d;
      crc_q       <= crc_d;
`endif
    end
  end

  assign m_tvalid    = out_vld_q;
  assign m_tdata     = out_dat_q[7:0];
  assign m_tlast     = out_dat_q[8];
  assign frames_ok   = ok_cnt_q;
  assign frames_drop = drop_cnt_q;
  assign overflow    = ovf_q;

endmodule
